// File: rtl/mcu_link_pkg.sv
// rtl/mcu_link_pkg.sv - shared types and constants for the MCU sensor-frame link
package mcu_link_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2,
    XFER    = 2'd3
  } state_e;

  localparam int         PACKET_BITS = 128;
  localparam logic [7:0] HEADER_BYTE = 8'hAA;
  localparam int         QUAT_W      = 64;
  localparam int         GYRO_W      = 48;
  localparam int         FLAG_QUAT   = 0;
  localparam int         FLAG_GYRO   = 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mcu_frame_scheduler_if.sv
// rtl/mcu_frame_scheduler_if.sv - sensor inputs, MCU handshake and frozen snapshot bundle
interface mcu_frame_scheduler_if;
  import mcu_link_pkg::*;

  logic              quat_valid;
  logic [QUAT_W-1:0] quat_data;
  logic              gyro_valid;
  logic [GYRO_W-1:0] gyro_data;
  logic              load;
  logic              sck;
  logic              done;
  logic [QUAT_W-1:0] snap_quat;
  logic [GYRO_W-1:0] snap_gyro;
  logic              snap_quat_valid;
  logic              snap_gyro_valid;
  logic [7:0]        seq_num;
  logic [7:0]        overrun_cnt;
  logic              xfer_timeout;

  modport master (
    output quat_valid, quat_data, gyro_valid, gyro_data, load, sck,
    input  done, snap_quat, snap_gyro, snap_quat_valid, snap_gyro_valid,
           seq_num, overrun_cnt, xfer_timeout
  );

  modport slave (
    input  quat_valid, quat_data, gyro_valid, gyro_data, load, sck,
    output done, snap_quat, snap_gyro, snap_quat_valid, snap_gyro_valid,
           seq_num, overrun_cnt, xfer_timeout
  );

endinterface

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer followed by a registered rising-edge pulse
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/mcu_frame_scheduler.sv
// rtl/mcu_frame_scheduler.sv - coalesces sensor pulses into frames and runs the DONE/LOAD/SCK handshake
module mcu_frame_scheduler
  import mcu_link_pkg::*;
#(
  parameter int COALESCE_CYCLES = 16,
  parameter int FRAME_BITS      = PACKET_BITS,
  parameter int XFER_TIMEOUT    = 300000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mcu_frame_scheduler_if.slave bus
);

  localparam int CW = (COALESCE_CYCLES > 1) ? $clog2(COALESCE_CYCLES) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int TW = (XFER_TIMEOUT > 1) ? $clog2(XFER_TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [QUAT_W-1:0] stg_quat_q, stg_quat_d, snap_quat_q, snap_quat_d;
  logic [GYRO_W-1:0] stg_gyro_q, stg_gyro_d, snap_gyro_q, snap_gyro_d;
  logic [1:0]        stg_flags_q, stg_flags_d, snap_flags_q, snap_flags_d;
  logic [CW-1:0]     coal_q, coal_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        seq_q, seq_d, ovr_q, ovr_d;
  logic              tout_q, tout_d;
  logic              done_q;

  logic       load_rise, sck_rise;
  logic [1:0] vld, flags_in;
  logic       stage_en, commit, tmo_hit, xfer_end;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(bus.load),
    .rise_o (load_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(bus.sck),
    .rise_o (sck_rise)
  );

  always_comb begin
    vld            = '0;
    vld[FLAG_QUAT] = bus.quat_valid;
    vld[FLAG_GYRO] = bus.gyro_valid;
  end

  // Staging absorbs valids everywhere except a READY cycle without load, where they hit the snapshot.
  assign flags_in = stg_flags_q | vld;
  assign stage_en = (state_q != READY) || load_rise;
  assign tmo_hit  = (state_q == XFER) && (tmo_q == TW'(XFER_TIMEOUT - 1));
  assign xfer_end = tmo_hit || (sck_rise && (bit_q == BW'(FRAME_BITS - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      stg_quat_q   <= '0;
      stg_gyro_q   <= '0;
      stg_flags_q  <= '0;
      snap_quat_q  <= '0;
      snap_gyro_q  <= '0;
      snap_flags_q <= '0;
      coal_q       <= '0;
      bit_q        <= '0;
      tmo_q        <= '0;
      seq_q        <= '0;
      ovr_q        <= '0;
      tout_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stg_quat_q   <= stg_quat_d;
      stg_gyro_q   <= stg_gyro_d;
      stg_flags_q  <= stg_flags_d;
      snap_quat_q  <= snap_quat_d;
      snap_gyro_q  <= snap_gyro_d;
      snap_flags_q <= snap_flags_d;
      coal_q       <= coal_d;
      bit_q        <= bit_d;
      tmo_q        <= tmo_d;
      seq_q        <= seq_d;
      ovr_q        <= ovr_d;
      tout_q       <= tout_d;
      done_q       <= (state_q == READY);
    end
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (&vld) begin
          commit  = 1'b1;
          state_d = READY;
        end else if (|vld) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if ((&flags_in) || (coal_q == CW'(COALESCE_CYCLES - 1))) begin
          commit  = 1'b1;
          state_d = READY;
        end
      end
      READY: begin
        if (load_rise) state_d = XFER;
      end
      XFER: begin
        if (xfer_end) begin
          if (|flags_in) begin
            commit  = 1'b1;
            state_d = READY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stg_quat_d   = stg_quat_q;
    stg_gyro_d   = stg_gyro_q;
    stg_flags_d  = stg_flags_q;
    snap_quat_d  = snap_quat_q;
    snap_gyro_d  = snap_gyro_q;
    snap_flags_d = snap_flags_q;
    seq_d        = seq_q;
    ovr_d        = ovr_q;
    if (stage_en) begin
      if (bus.quat_valid) stg_quat_d = bus.quat_data;
      if (bus.gyro_valid) stg_gyro_d = bus.gyro_data;
      stg_flags_d = flags_in;
    end
    if (commit) begin
      snap_quat_d  = stg_quat_d;
      snap_gyro_d  = stg_gyro_d;
      snap_flags_d = flags_in;
      seq_d        = seq_q + 8'd1;
      stg_flags_d  = '0;
    end else if ((state_q == READY) && !load_rise && (|vld)) begin
      if (bus.quat_valid) begin
        snap_quat_d            = bus.quat_data;
        snap_flags_d[FLAG_QUAT] = 1'b1;
      end
      if (bus.gyro_valid) begin
        snap_gyro_d            = bus.gyro_data;
        snap_flags_d[FLAG_GYRO] = 1'b1;
      end
      ovr_d = sat_inc8(ovr_q);
    end
    coal_d = (state_q == COLLECT) ? coal_q + CW'(1) : '0;
    tmo_d  = (state_q == XFER) ? tmo_q + TW'(1) : '0;
    bit_d  = '0;
    if (state_q == XFER) bit_d = sck_rise ? bit_q + BW'(1) : bit_q;
    tout_d = tout_q | tmo_hit;
  end

  assign bus.done            = done_q;
  assign bus.snap_quat       = snap_quat_q;
  assign bus.snap_gyro       = snap_gyro_q;
  assign bus.snap_quat_valid = snap_flags_q[FLAG_QUAT];
  assign bus.snap_gyro_valid = snap_flags_q[FLAG_GYRO];
  assign bus.seq_num         = seq_q;
  assign bus.overrun_cnt     = ovr_q;
  assign bus.xfer_timeout    = tout_q;

endmodule

// File: doc/mcu_frame_scheduler.md
Name: mcu_frame_scheduler

Overview:
- Sequences sensor frames from the BNO085 controller toward the MCU SPI slave.
- Coalesces the quaternion and gyro valid pulses into one frame and commits it to a frozen snapshot that feeds the SPI packet buffer.
- Owns the DONE/LOAD handshake with the MCU, counts SPI clocks to detect end-of-frame, and buffers one pending frame that arrives mid-transfer.

Parameters:
- COALESCE_CYCLES, 16: max clk cycles to wait for the partner pulse after the first valid pulse.
- FRAME_BITS, 128: SCK rising edges per SPI frame (16 bytes).
- XFER_TIMEOUT, 300000: clk cycles allowed in XFER before forced end (~100 ms at 3 MHz).
- SYNC_STAGES, 2: flops in each SCK/LOAD synchronizer.

Ports:
- clk  in  1  FPGA system clock
- rst  in  1  asynchronous, active-high reset
- quat_valid  in  1  one-cycle pulse, quaternion sample present
- quat_data  in  64  {w,x,y,z}, signed 16 bits each
- gyro_valid  in  1  one-cycle pulse, gyro sample present
- gyro_data  in  48  {x,y,z}, signed 16 bits each
- load  in  1  MCU acknowledge, asynchronous to clk
- sck  in  1  SPI clock from MCU, asynchronous to clk
- done  out  1  frame ready to MCU, registered
- snap_quat  out  64  frozen quaternion for the packet
- snap_gyro  out  48  frozen gyro for the packet
- snap_quat_valid  out  1  quaternion field is fresh in this frame
- snap_gyro_valid  out  1  gyro field is fresh in this frame
- seq_num  out  8  committed-frame counter
- overrun_cnt  out  8  frames overwritten before MCU ack
- xfer_timeout  out  1  sticky, set when a transfer timed out

Behaviour:
- Reset (async, active-high): state IDLE; all outputs, staging registers, pending flags and counters = 0.
- load and sck each pass through SYNC_STAGES flops followed by a rising-edge detector. clk must be at least 4× the SCK frequency.
- Commit means: copy staging data and flags to the snap_* outputs, seq_num += 1 (wraps 255 to 0), clear staging flags.
- IDLE:
  - Both valids in the same cycle: capture both, commit, go to READY.
  - One valid: capture it, clear coalesce counter, go to COLLECT.
- COLLECT:
  - Further valids overwrite their staging field (latest wins).
  - Commit and go to READY when both flags are set or the counter reaches COALESCE_CYCLES-1.
- READY:
  - done = 1 (registered, so it rises the cycle after entry).
  - A valid pulse writes straight into snap_*, sets its snap flag, and increments overrun_cnt (saturates at 255). seq_num does not change.
  - Synced load rising edge: go to XFER, clear bit and timeout counters. done is 0 from the next cycle.
- XFER:
  - snap_* is frozen.
  - Valid pulses go into staging and set pending flags.
  - Each synced SCK rising edge increments bit_cnt.
  - bit_cnt reaching FRAME_BITS, or the timeout counter reaching XFER_TIMEOUT (also sets xfer_timeout), ends the transfer.
  - At end: any pending flag set → commit and go to READY; otherwise go to IDLE.
- Load edge in IDLE/COLLECT/XFER: ignored.
- Load edge and valid in the same READY cycle: load wins. The valid goes to staging as pending and overrun_cnt is unchanged.
- Reset mid-XFER: done drops immediately, snapshot clears, bit count is discarded. The SPI frame in flight is not recovered.
- No combinational path from any input to any output.

Decomposition:
- Package mcu_link_pkg:
  - state enum {IDLE, COLLECT, READY, XFER}
  - PACKET_BITS = 128, HEADER_BYTE = 8'hAA
  - QUAT_W = 64, GYRO_W = 48
  - flag bit positions (bit0 quat, bit1 gyro)
- One sub-module, sync_edge_detect (SYNC_STAGES synchronizer plus registered rising-edge pulse), instantiated for load and sck.

Test Plan:
- Reset, then quat_valid with quat_data=64'h0001_0002_0003_0004 and gyro_valid 5 cycles later → one commit, seq_num=1, both snap flags 1, done=1.
- quat_valid only, no gyro for 16 cycles → commit on cycle 16, snap_gyro_valid=0, snap_gyro=0.
- In READY, apply 3 further quat pulses before load → snap_quat equals the last value, overrun_cnt=3, seq_num unchanged.
- Load rise, gyro pulse at SCK edge 40, 128 SCK edges → done low during transfer, snapshot stable, then done re-asserts with seq_num+1.
- Load rise, then only 20 SCK edges → after XFER_TIMEOUT cycles xfer_timeout=1, state IDLE, done=0.
- Assert rst at SCK edge 64 of a transfer → all outputs 0. The next valid pulse produces seq_num=1.
